// File: rtl/serial_mult_pkg.sv
// serial_mult_pkg
// Shared definitions for the bit-serial shift-and-add multiplier:
//   state_e        controller states (IDLE, ADD, DONE)
//   WIDTH_DEFAULT  default operand width
//   latency(w)     cycles spent in ADD for a w x w product (2*w*w)
package serial_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 4;

  // Every pass walks all 2*w accumulator bits, and there is one pass per
  // multiplier bit, so the ADD phase length does not depend on the data.
  function automatic int latency(input int w);
    return 2 * w * w;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell
// Combinational one-bit full adder. This is the only arithmetic element of
// the serial multiplier; the sequencer time-shares it across all bit steps.
// Ports:
//   a, b  in   addend bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_mult_seq.sv
// serial_mult_seq
// Unsigned WIDTH x WIDTH bit-serial multiplier. For each multiplier bit i the
// accumulator is streamed through one full adder, bit j per cycle, together
// with the multiplicand bit a[j-i] gated by b[i]; the carry lives in a flop.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   abort    in   synchronous cancel while busy
//   a, b     in   multiplicand / multiplier (unsigned, WIDTH bits)
//   busy     out  high in ADD and DONE
//   done     out  one-cycle completion pulse
//   product  out  registered 2*WIDTH result, held until next completion
module serial_mult_seq
  import serial_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);
  localparam int JW = $clog2(PW);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d, product_q, product_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;

  logic [JW-1:0]   i_ext, rel;
  logic            in_window, a_bit, b_bit, acc_bit, addend;
  logic            fa_s, fa_cout;
  logic            j_last, i_last;

  // Bit-step operand selection. rel = j - i is the multiplicand bit that
  // lines up with accumulator bit j in pass i; outside the window the
  // shifted multiplicand contributes zero and only the carry ripples.
  always_comb begin
    i_ext     = JW'(i_q);
    rel       = j_q - i_ext;
    in_window = (j_q >= i_ext) && (rel < JW'(WIDTH));
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    acc_bit   = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (rel == JW'(k)) a_bit = a_q[k];
      if (i_q == IW'(k)) b_bit = b_q[k];
    end
    for (int k = 0; k < PW; k++) begin
      if (j_q == JW'(k)) acc_bit = acc_q[k];
    end
    addend = in_window & b_bit & a_bit;
    j_last = (j_q == JW'(PW - 1));
    i_last = (i_q == IW'(WIDTH - 1));
  end

  fa_cell u_fa (
    .a    (acc_bit),
    .b    (addend),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      carry_q   <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      carry_q   <= carry_d;
      i_q       <= i_d;
      j_q       <= j_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    carry_d   = carry_q;
    i_d       = i_q;
    j_d       = j_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          carry_d = 1'b0;
          i_d     = '0;
          j_d     = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          for (int k = 0; k < PW; k++) begin
            if (j_q == JW'(k)) acc_d[k] = fa_s;
          end
          if (j_last) begin
            // Carry out of the top bit is always 0: the product fits in PW bits.
            j_d     = '0;
            carry_d = 1'b0;
            if (i_last) begin
              state_d   = DONE;
              product_d = acc_d;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            carry_d = fa_cout;
            j_d     = j_q + JW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    product = product_q;
  end

endmodule
